// File: rtl/crypto_req_frontend.sv
// rtl/crypto_req_frontend.sv - processor request front-end for the crypto core
//
// Takes one request at a time from the processor. It holds the operands for the
// core, starts the core with a one-cycle bgn pulse and collects the result
// strobes. When the core finishes or times out, it presents a single response.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   req_valid/req_ready          request handshake; req_op, req_data, req_key operands
//   bgn                          one-cycle start pulse to the control unit
//   cript_or_decript             latched operation
//   fin_counter                  saturating round count
//   core_data, core_key          latched operands
//   core_rst_n                   active-low abort reset to the core
//   c0, c5, c19, c20, c21        control-unit strobes
//   core_bus                     core result bus
//   rsp_valid/rsp_ready          response handshake
//   rsp_data, rsp_key, rsp_err   response payload
module crypto_req_frontend #(
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [DATA_W-1:0] req_data,
    input  logic [DATA_W-1:0] req_key,
    output logic              bgn,
    output logic [1:0]        cript_or_decript,
    output logic [2:0]        fin_counter,
    output logic [DATA_W-1:0] core_data,
    output logic [DATA_W-1:0] core_key,
    output logic              core_rst_n,
    input  logic              c0,
    input  logic              c5,
    input  logic              c19,
    input  logic              c20,
    input  logic              c21,
    input  logic [DATA_W-1:0] core_bus,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [DATA_W-1:0] rsp_key,
    output logic              rsp_err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_RUN    = 3'd2,
        S_ABORT  = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    state_t              r_state;
    state_t              w_next;
    logic [TMO_W-1:0]    r_tmo;
    logic                r_abort_cnt;
    logic [1:0]          r_op;
    logic [2:0]          r_fin;
    logic [DATA_W-1:0]   r_core_data;
    logic [DATA_W-1:0]   r_core_key;
    logic                r_core_rst_n;
    logic [DATA_W-1:0]   r_rsp_data;
    logic [DATA_W-1:0]   r_rsp_key;
    logic                r_rsp_err;

    logic                w_accept;
    logic                w_legal;
    logic                w_tmo_hit;
    // c0 only reports that the core loaded its operands; nothing here depends on it.
    logic                w_unused_c0;

    assign w_unused_c0 = c0;
    assign w_accept    = req_valid && (r_state == S_IDLE);
    assign w_legal     = (req_op == 2'b01) || (req_op == 2'b10);
    // r_tmo counts RUN cycles already completed, so this is the TIMEOUT-th RUN cycle.
    assign w_tmo_hit   = (r_tmo == TMO_W'(TIMEOUT - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = w_legal ? S_LAUNCH : S_RESP;
            S_LAUNCH: w_next = S_RUN;
            S_RUN: begin
                if (c21)            w_next = S_RESP;
                else if (w_tmo_hit) w_next = S_ABORT;
            end
            S_ABORT:  if (r_abort_cnt) w_next = S_RESP;
            S_RESP:   if (rsp_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_tmo        <= '0;
            r_abort_cnt  <= 1'b0;
            r_op         <= 2'b00;
            r_fin        <= 3'd0;
            r_core_data  <= '0;
            r_core_key   <= '0;
            r_core_rst_n <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_key    <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_state      <= w_next;
            // Registered from the next state so the core reset is low exactly while in ABORT.
            r_core_rst_n <= (w_next != S_ABORT);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op        <= req_op;
                        r_core_data <= req_data;
                        r_core_key  <= req_key;
                        r_rsp_data  <= '0;
                        r_rsp_key   <= '0;
                        r_rsp_err   <= !w_legal;
                        if (w_legal) begin
                            r_fin <= 3'd0;
                            r_tmo <= '0;
                        end
                    end
                end
                S_RUN: begin
                    r_tmo <= r_tmo + 1'b1;
                    if (c5 && (r_fin != 3'b111)) r_fin <= r_fin + 3'd1;
                    if (c19) r_rsp_data <= core_bus;
                    if (c20) r_rsp_key  <= core_bus;
                    if (c21)            r_rsp_err   <= 1'b0;
                    else if (w_tmo_hit) r_abort_cnt <= 1'b0;
                end
                S_ABORT: begin
                    r_abort_cnt <= 1'b1;
                    if (r_abort_cnt) r_rsp_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign req_ready        = (r_state == S_IDLE);
    assign bgn              = (r_state == S_LAUNCH);
    assign rsp_valid        = (r_state == S_RESP);
    assign cript_or_decript = r_op;
    assign fin_counter      = r_fin;
    assign core_data        = r_core_data;
    assign core_key         = r_core_key;
    assign core_rst_n       = r_core_rst_n;
    assign rsp_data         = r_rsp_data;
    assign rsp_key          = r_rsp_key;
    assign rsp_err          = r_rsp_err;

endmodule
